face_box_overlay: RTL

//  Display-side consumer of the face bounding box (x_min/x_max/y_min/y_max) from the binary-image
//  box extractor. Takes the RGB565 video stream going to the LCD and draws a solid-colour rectangle

---
 rtl/face_pkg.sv | 9 +
 rtl/face_box_edge_cmp.sv | 19 +
 rtl/face_box_overlay.sv | 135 +++++++++++++
 3 files changed

// File: rtl/face_pkg.sv
// face_pkg: shared image defaults, RGB565 colours and overlay FSM encoding
package face_pkg;
   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;
   localparam logic [15:0] RGB_RED   = 16'hF800;
   localparam logic [15:0] RGB_BLUE  = 16'h001F;
   localparam logic [15:0] RGB_BLACK = 16'h0000;
   typedef enum logic [1:0] {S_IDLE, S_ARM, S_DRAW, S_PASS} state_e;
endpackage

// File: rtl/face_box_edge_cmp.sv
// face_box_edge_cmp: one-axis box test, reports whether a coordinate lies in
// [lo..hi] and whether it lies within BORDER pixels of either bound.
//   coord_i    current pixel coordinate (11-bit, zero-extended)
//   lo_i/hi_i  inclusive bounds
//   in_range_o lo_i <= coord_i <= hi_i
//   on_edge_o  coord_i within BORDER of lo_i or hi_i (meaningful only when in range)
module face_box_edge_cmp #(
   parameter int BORDER = 2
) (
   input  logic [10:0] coord_i,
   input  logic [10:0] lo_i,
   input  logic [10:0] hi_i,
   output logic        in_range_o,
   output logic        on_edge_o
);
   assign in_range_o = coord_i >= lo_i && coord_i <= hi_i;
   // the differences may wrap when out of range; in_range_o masks that case
   assign on_edge_o = (coord_i - lo_i < 11'(BORDER)) || (hi_i - coord_i < 11'(BORDER));
endmodule

// File: rtl/face_box_overlay.sv
// face_box_overlay: draws a BOX_COLOR rectangle outline over an RGB565 stream
// at the face box latched on each vsync rise; 2-clk latency on all outputs.
//   clk, rst_n                     pixel clock, async active-low reset
//   per_frame_vsync/href/clken     input frame, line and pixel strobes
//   per_img_rgb                    input pixel
//   x_min/x_max/y_min/y_max        box bounds from the extractor (inclusive)
//   post_frame_vsync/href/clken    strobes delayed 2 clk
//   post_img                       outline colour on the box edge, else delayed pixel; 0 outside href
//   box_valid                      box latched for this frame passed the sanity checks
module face_box_overlay
   import face_pkg::*;
#(
   parameter int          IMG_W     = IMG_W_DEF,
   parameter int          IMG_H     = IMG_H_DEF,
   parameter int          BORDER    = 2,
   parameter int          MIN_SIZE  = 8,
   parameter logic [15:0] BOX_COLOR = RGB_RED
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic        per_frame_clken,
   input  logic [15:0] per_img_rgb,
   input  logic [9:0]  x_min,
   input  logic [9:0]  x_max,
   input  logic [9:0]  y_min,
   input  logic [9:0]  y_max,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic        post_frame_clken,
   output logic [15:0] post_img,
   output logic        box_valid
);
   state_e      state_q, state_d;
   logic        vsync_q, vs_rise, pix, last_x, box_ok, draw_en, hit_d;
   logic        in_x, in_y, edge_x, edge_y, box_valid_q;
   logic [9:0]  cnt_x_q, cnt_y_q, cnt_x_d, cnt_y_d, cur_x, cur_y;
   logic [9:0]  xmn_q, xmx_q, ymn_q, ymx_q;
   logic [10:0] xa, xb, ya, yb;
   logic        vs_d1_q, hs_d1_q, ce_d1_q, hit_q, vs_d2_q, hs_d2_q, ce_d2_q;
   logic [15:0] rgb_d1_q, img_q, img_d;

   assign vs_rise = per_frame_vsync & ~vsync_q;
   assign pix     = per_frame_clken & per_frame_href;

   // a pixel arriving with the vsync rise sees the cleared counters as its coordinate
   always_comb begin
      cur_x   = vs_rise ? '0 : cnt_x_q;
      cur_y   = vs_rise ? '0 : cnt_y_q;
      last_x  = cur_x == 10'(IMG_W - 1);
      cnt_x_d = pix ? (last_x ? '0 : cur_x + 10'd1) : cur_x;
      cnt_y_d = (pix && last_x && cur_y < 10'(IMG_H)) ? cur_y + 10'd1 : cur_y;
   end

   always_comb begin
      xa = {1'b0, x_min};
      xb = {1'b0, x_max};
      ya = {1'b0, y_min};
      yb = {1'b0, y_max};
      box_ok = xb >= xa && yb >= ya &&
               (xb - xa + 11'd1) >= 11'(MIN_SIZE) && (yb - ya + 11'd1) >= 11'(MIN_SIZE) &&
               xb < 11'(IMG_W) && yb < 11'(IMG_H);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;

   always_comb
      state_d = (state_q == S_ARM) ? (box_valid_q ? S_DRAW : S_PASS) :
                vs_rise            ? S_ARM : state_q;

   always_comb draw_en = state_q == S_DRAW;

   face_box_edge_cmp #(.BORDER(BORDER)) u_cmp_x (
      .coord_i({1'b0, cur_x}), .lo_i({1'b0, xmn_q}), .hi_i({1'b0, xmx_q}),
      .in_range_o(in_x), .on_edge_o(edge_x)
   );

   face_box_edge_cmp #(.BORDER(BORDER)) u_cmp_y (
      .coord_i({1'b0, cur_y}), .lo_i({1'b0, ymn_q}), .hi_i({1'b0, ymx_q}),
      .in_range_o(in_y), .on_edge_o(edge_y)
   );

   assign hit_d = draw_en & in_x & in_y & (edge_x | edge_y);
   assign img_d = hs_d1_q ? (hit_q ? BOX_COLOR : rgb_d1_q) : '0;

   // vsync_q resets high so a reset released mid-frame (vsync still high)
   // does not look like a frame start
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vsync_q     <= 1'b1;
         cnt_x_q     <= '0;
         cnt_y_q     <= '0;
         xmn_q       <= 10'(IMG_W);
         xmx_q       <= '0;
         ymn_q       <= 10'(IMG_H);
         ymx_q       <= '0;
         box_valid_q <= 1'b0;
         vs_d1_q     <= 1'b0;
         hs_d1_q     <= 1'b0;
         ce_d1_q     <= 1'b0;
         rgb_d1_q    <= '0;
         hit_q       <= 1'b0;
         vs_d2_q     <= 1'b0;
         hs_d2_q     <= 1'b0;
         ce_d2_q     <= 1'b0;
         img_q       <= '0;
      end else begin
         vsync_q     <= per_frame_vsync;
         cnt_x_q     <= cnt_x_d;
         cnt_y_q     <= cnt_y_d;
         xmn_q       <= vs_rise ? x_min : xmn_q;
         xmx_q       <= vs_rise ? x_max : xmx_q;
         ymn_q       <= vs_rise ? y_min : ymn_q;
         ymx_q       <= vs_rise ? y_max : ymx_q;
         box_valid_q <= vs_rise ? box_ok : box_valid_q;
         vs_d1_q     <= per_frame_vsync;
         hs_d1_q     <= per_frame_href;
         ce_d1_q     <= per_frame_clken;
         rgb_d1_q    <= per_img_rgb;
         hit_q       <= hit_d;
         vs_d2_q     <= vs_d1_q;
         hs_d2_q     <= hs_d1_q;
         ce_d2_q     <= ce_d1_q;
         img_q       <= img_d;
      end

   assign post_frame_vsync = vs_d2_q;
   assign post_frame_href  = hs_d2_q;
   assign post_frame_clken = ce_d2_q;
   assign post_img         = img_q;
   assign box_valid        = box_valid_q;
endmodule
